// File: rtl/ctl_pkg.sv
// Shared definitions for the hardwired instruction sequencer:
// opcode constants, state encoding, strobe bundle and opcode classifier.
package ctl_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T1W    = 4'd3,
    S_T2     = 4'd4,
    S_T3     = 4'd5,
    S_T4     = 4'd6,
    S_T5     = 4'd7,
    S_T6     = 4'd8,
    S_HALTED = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // Single-bit datapath strobes, one field per control input.
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic lo_in;
    logic hi_in;
  } strobes_t;

  function automatic op_class_e op_class(input logic [OP_W-1:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: cls = CLS_ALU;
      OP_MUL, OP_DIV:                                 cls = CLS_MULDIV;
      OP_NOP:                                         cls = CLS_NOP;
      OP_HALT:                                        cls = CLS_HALT;
      default:                                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> datapath bundle: run/stop/memory handshake and IR in,
// control strobes and status out.
interface instr_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPCODE_W = 5
) ();

  logic                run;
  logic                stop;
  logic                mem_ready;
  logic [DATA_W-1:0]   ir;

  logic                PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic                Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [NUM_REGS-1:0] reg_out_sel;
  logic [NUM_REGS-1:0] reg_in_sel;
  logic [OPCODE_W-1:0] alu_op;
  logic                busy, done, illegal_op, halted;

  modport master (
    input  run, stop, mem_ready, ir,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin,
           reg_out_sel, reg_in_sel, alu_op, busy, done, illegal_op, halted
  );

  modport slave (
    output run, stop, mem_ready, ir,
    input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin,
           reg_out_sel, reg_in_sel, alu_op, busy, done, illegal_op, halted
  );

endinterface

// File: rtl/ctl_step_decode.sv
// Moore output decode: current control step plus IR fields -> strobes.
module ctl_step_decode
  import ctl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int REG_SEL_W = 4,
  parameter int OPCODE_W  = 5
) (
  input  state_e              state,
  input  logic [DATA_W-1:0]   ir,
  output strobes_t            strobes,
  output logic [NUM_REGS-1:0] reg_out_sel,
  output logic [NUM_REGS-1:0] reg_in_sel,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal_op,
  output logic                halted
);

  localparam int RA_MSB = DATA_W - OPCODE_W - 1;
  localparam int RB_MSB = RA_MSB - REG_SEL_W;
  localparam int RC_MSB = RB_MSB - REG_SEL_W;

  logic [OPCODE_W-1:0]  opcode;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  op_class_e            cls;
  logic                 unused_ir_low;

  assign opcode        = ir[DATA_W-1 -: OPCODE_W];
  assign ra            = ir[RA_MSB -: REG_SEL_W];
  assign rb            = ir[RB_MSB -: REG_SEL_W];
  assign rc            = ir[RC_MSB -: REG_SEL_W];
  assign cls           = op_class(opcode);
  assign unused_ir_low = ^ir[RC_MSB-REG_SEL_W:0];

  // Strobe decode for the current T-step.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    strobes     = '0;
    reg_out_sel = '0;
    reg_in_sel  = '0;
    alu_op      = '0;
    busy        = 1'b1;
    done        = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    unique case (state)
      S_IDLE: busy = 1'b0;
      S_T0: begin
        strobes.pc_out = 1'b1;
        strobes.mar_in = 1'b1;
        strobes.inc_pc = 1'b1;
        strobes.z_in   = 1'b1;
      end
      S_T1: begin
        strobes.zlow_out = 1'b1;
        strobes.pc_in    = 1'b1;
        strobes.read     = 1'b1;
        strobes.mdr_in   = 1'b1;
      end
      // Waiting on memory: keep reading but never reload the PC.
      S_T1W: begin
        strobes.read   = 1'b1;
        strobes.mdr_in = 1'b1;
      end
      S_T2: begin
        strobes.mdr_out = 1'b1;
        strobes.ir_in   = 1'b1;
      end
      S_T3: begin
        unique case (cls)
          CLS_ALU: begin
            reg_out_sel  = NUM_REGS'(1) << rb;
            strobes.y_in = 1'b1;
          end
          CLS_MULDIV: begin
            reg_out_sel  = NUM_REGS'(1) << ra;
            strobes.y_in = 1'b1;
          end
          CLS_NOP: done = 1'b1;
          CLS_HALT: ;
          default: begin
            illegal_op = 1'b1;
            done       = 1'b1;
          end
        endcase
      end
      S_T4: begin
        reg_out_sel  = (cls == CLS_MULDIV) ? NUM_REGS'(1) << rb : NUM_REGS'(1) << rc;
        strobes.z_in = 1'b1;
        alu_op       = opcode;
      end
      S_T5: begin
        strobes.zlow_out = 1'b1;
        if (cls == CLS_MULDIV) begin
          strobes.lo_in = 1'b1;
        end else begin
          reg_in_sel = NUM_REGS'(1) << ra;
          done       = 1'b1;
        end
      end
      S_T6: begin
        strobes.zhigh_out = 1'b1;
        strobes.hi_in     = 1'b1;
        done              = 1'b1;
      end
      S_HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Hardwired fetch/execute sequencer: owns the T-step register and the
// next-step logic; strobe decode lives in ctl_step_decode.
module instr_sequencer
  import ctl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int REG_SEL_W = 4,
  parameter int OPCODE_W  = 5
) (
  input logic               clk,
  input logic               clr,
  instr_sequencer_if.master bus
);

  state_e              state, state_next;
  strobes_t            strobes;
  logic [NUM_REGS-1:0] reg_out_sel, reg_in_sel;
  logic [OPCODE_W-1:0] alu_op;
  logic                busy, done, illegal_op, halted;
  op_class_e           cls;

  assign cls = op_class(bus.ir[DATA_W-1 -: OPCODE_W]);

  ctl_step_decode #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .REG_SEL_W(REG_SEL_W),
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .state      (state),
    .ir         (bus.ir),
    .strobes    (strobes),
    .reg_out_sel(reg_out_sel),
    .reg_in_sel (reg_in_sel),
    .alu_op     (alu_op),
    .busy       (busy),
    .done       (done),
    .illegal_op (illegal_op),
    .halted     (halted)
  );

  // Step register; clr drops straight back to IDLE, even mid-instruction.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: non-blocking so every flop samples pre-edge values.
    if (!clr) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next step; the done cycle is the single place stop is honoured.
  always_comb begin
    state_next = state;
    if (done) begin
      state_next = bus.stop ? S_IDLE : S_T0;
    end else begin
      unique case (state)
        S_IDLE:      if (bus.run) state_next = S_T0;
        S_T0:        state_next = S_T1;
        S_T1, S_T1W: state_next = bus.mem_ready ? S_T2 : S_T1W;
        S_T2:        state_next = S_T3;
        S_T3:        state_next = (cls == CLS_HALT) ? S_HALTED : S_T4;
        S_T4:        state_next = S_T5;
        S_T5:        state_next = S_T6;
        default:     state_next = state;
      endcase
    end
  end

  assign bus.PCout       = strobes.pc_out;
  assign bus.MARin       = strobes.mar_in;
  assign bus.IncPC       = strobes.inc_pc;
  assign bus.PCin        = strobes.pc_in;
  assign bus.Read        = strobes.read;
  assign bus.MDRin       = strobes.mdr_in;
  assign bus.MDRout      = strobes.mdr_out;
  assign bus.IRin        = strobes.ir_in;
  assign bus.Yin         = strobes.y_in;
  assign bus.Zin         = strobes.z_in;
  assign bus.Zlowout     = strobes.zlow_out;
  assign bus.Zhighout    = strobes.zhigh_out;
  assign bus.LOin        = strobes.lo_in;
  assign bus.HIin        = strobes.hi_in;
  assign bus.reg_out_sel = reg_out_sel;
  assign bus.reg_in_sel  = reg_in_sel;
  assign bus.alu_op      = alu_op;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.illegal_op  = illegal_op;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: each instruction pushes its expected per-cycle output
// vector (with the inputs to drive that cycle); the driver pops and compares.
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic [15:0] reg_out_sel;
    logic [15:0] reg_in_sel;
    logic [4:0]  alu_op;
    logic busy, done, illegal_op, halted;
  } obs_t;

  typedef struct {
    string       tag;
    logic [31:0] ir;
    logic        run;
    logic        stop;
    logic        mem_ready;
    obs_t        exp;
  } item_t;

  item_t sb[$];
  obs_t  obs;
  int    checks   = 0;
  int    failures = 0;

  always_comb begin
    obs             = '0;
    obs.pc_out      = bus.PCout;
    obs.mar_in      = bus.MARin;
    obs.inc_pc      = bus.IncPC;
    obs.pc_in       = bus.PCin;
    obs.read        = bus.Read;
    obs.mdr_in      = bus.MDRin;
    obs.mdr_out     = bus.MDRout;
    obs.ir_in       = bus.IRin;
    obs.y_in        = bus.Yin;
    obs.z_in        = bus.Zin;
    obs.zlow_out    = bus.Zlowout;
    obs.zhigh_out   = bus.Zhighout;
    obs.lo_in       = bus.LOin;
    obs.hi_in       = bus.HIin;
    obs.reg_out_sel = bus.reg_out_sel;
    obs.reg_in_sel  = bus.reg_in_sel;
    obs.alu_op      = bus.alu_op;
    obs.busy        = bus.busy;
    obs.done        = bus.done;
    obs.illegal_op  = bus.illegal_op;
    obs.halted      = bus.halted;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] ir_v, input logic run_v,
                      input logic stop_v, input logic mr_v, input obs_t e);
    item_t it;
    it.tag       = tag;
    it.ir        = ir_v;
    it.run       = run_v;
    it.stop      = stop_v;
    it.mem_ready = mr_v;
    it.exp       = e;
    sb.push_back(it);
  endtask

  task automatic push_idle(input string name, input int n, input logic run_v);
    for (int i = 0; i < n; i++) push($sformatf("%s_%0d", name, i), 32'h0, run_v, 1'b0, 1'b0, '0);
  endtask

  task automatic push_halted(input int n);
    obs_t e;
    e        = '0;
    e.halted = 1'b1;
    for (int i = 0; i < n; i++) push($sformatf("halted_%0d", i), 32'hD800_0000, 1'b1, 1'b0, 1'b1, e);
  endtask

  // Expected step sequence written from the instruction's class and fields.
  task automatic push_instr(input string name, input logic [31:0] ir_v, input int waits,
                            input logic stop_t3);
    obs_t        e;
    logic [4:0]  op;
    logic [15:0] oa, ob, oc;
    bit          alu, md;
    op  = ir_v[31:27];
    oa  = 16'h1 << ir_v[26:23];
    ob  = 16'h1 << ir_v[22:19];
    oc  = 16'h1 << ir_v[18:15];
    alu = op inside {[5'b00011:5'b01000]};
    md  = (op == 5'b01111) || (op == 5'b10000);

    e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    push({name, "_T0"}, ir_v, 1'b1, 1'b0, 1'b0, e);
    e = '0; e.busy = 1; e.zlow_out = 1; e.pc_in = 1; e.read = 1; e.mdr_in = 1;
    push({name, "_T1"}, ir_v, 1'b1, 1'b0, (waits == 0), e);
    for (int w = 0; w < waits; w++) begin
      e = '0; e.busy = 1; e.read = 1; e.mdr_in = 1;
      push($sformatf("%s_T1W%0d", name, w), ir_v, 1'b1, 1'b0, (w == waits - 1), e);
    end
    e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1;
    push({name, "_T2"}, ir_v, 1'b1, 1'b0, 1'b0, e);

    e = '0; e.busy = 1;
    if (alu) begin
      e.reg_out_sel = ob; e.y_in = 1;
    end else if (md) begin
      e.reg_out_sel = oa; e.y_in = 1;
    end else if (op == 5'b11010) begin
      e.done = 1;
    end else if (op != 5'b11011) begin
      e.illegal_op = 1; e.done = 1;
    end
    push({name, "_T3"}, ir_v, 1'b1, stop_t3, 1'b0, e);

    if (alu || md) begin
      e = '0; e.busy = 1; e.z_in = 1; e.alu_op = op;
      e.reg_out_sel = md ? ob : oc;
      push({name, "_T4"}, ir_v, 1'b1, stop_t3, 1'b0, e);
      e = '0; e.busy = 1; e.zlow_out = 1;
      if (md) e.lo_in = 1;
      else begin
        e.reg_in_sel = oa; e.done = 1;
      end
      push({name, "_T5"}, ir_v, 1'b1, stop_t3, 1'b0, e);
      if (md) begin
        e = '0; e.busy = 1; e.zhigh_out = 1; e.hi_in = 1; e.done = 1;
        push({name, "_T6"}, ir_v, 1'b1, stop_t3, 1'b0, e);
      end
    end
  endtask

  // Entered just after a rising edge; drives, samples on the falling edge.
  task automatic drain_n(input int n);
    item_t it;
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      it            = sb.pop_front();
      bus.ir        = it.ir;
      bus.run       = it.run;
      bus.stop      = it.stop;
      bus.mem_ready = it.mem_ready;
      @(negedge clk);
      check(it.tag, 64'(obs), 64'(it.exp));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    drain_n(sb.size());
  endtask

  initial begin
    item_t it;
    clr           = 1'b0;
    bus.run       = 1'b1;
    bus.stop      = 1'b0;
    bus.mem_ready = 1'b1;
    bus.ir        = 32'h2891_8000;

    repeat (2) begin
      @(negedge clk);
      check("reset_hold", 64'(obs), 64'(0));
    end
    @(posedge clk);
    #1;
    clr     = 1'b1;
    bus.run = 1'b0;

    // Back-to-back instructions, then a stop raised in T3.
    push_idle("idle", 1, 1'b0);
    push_idle("idle_go", 1, 1'b1);
    push_instr("and", 32'h2891_8000, 0, 1'b0);
    push_instr("sub_w3", {5'b00100, 4'd5, 4'd6, 4'd7, 15'd0}, 3, 1'b0);
    push_instr("mul", 32'h79A0_0000, 0, 1'b0);
    push_instr("div_w1", {5'b10000, 4'd9, 4'd10, 4'd0, 15'd0}, 1, 1'b0);
    push_instr("nop", 32'hD000_0000, 0, 1'b0);
    push_instr("illegal", 32'hF800_0000, 0, 1'b0);
    push_instr("shr_stop", {5'b00111, 4'd15, 4'd0, 4'd14, 15'd0}, 2, 1'b1);
    push_idle("after_stop", 3, 1'b0);
    drain();

    // Asynchronous clear in the middle of T4.
    push_idle("go2", 1, 1'b1);
    push_instr("or_clr", {5'b00110, 4'd2, 4'd3, 4'd4, 15'd0}, 0, 1'b0);
    drain_n(5);
    it            = sb.pop_front();
    bus.ir        = it.ir;
    bus.mem_ready = it.mem_ready;
    @(negedge clk);
    check(it.tag, 64'(obs), 64'(it.exp));
    #2;
    clr = 1'b0;
    #1;
    check("clr_mid_zin", 64'(obs.z_in), 64'(0));
    check("clr_mid_out_sel", 64'(obs.reg_out_sel), 64'(0));
    check("clr_mid_all", 64'(obs), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    check("clr_held", 64'(obs), 64'(0));
    clr     = 1'b1;
    bus.run = 1'b0;
    push_idle("after_clr", 2, 1'b0);

    // HALT parks the sequencer with run held high.
    push_idle("go3", 1, 1'b1);
    push_instr("halt", 32'hD800_0000, 0, 1'b0);
    push_halted(12);
    drain();
    clr = 1'b0;
    @(negedge clk);
    check("halt_clr", 64'(obs), 64'(0));
    @(posedge clk);
    #1;
    clr     = 1'b1;
    bus.run = 1'b0;

    // Restart after the clear.
    push_idle("post_halt", 2, 1'b0);
    push_idle("go4", 1, 1'b1);
    push_instr("add_final", {5'b00011, 4'd4, 4'd1, 4'd2, 15'd0}, 1, 1'b1);
    push_idle("end", 2, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Hardwired control sequencer that replaces hand-driven control-step stimulus; walks the fetch/execute T-steps and drives the datapath control strobes.
- Covers three-register ALU ops and two-register MUL/DIV writing HI/LO.
- Adds a variable-latency memory-read handshake, run/stop control, halt and illegal-opcode detection.
- Sits between the IR output and the datapath control inputs.

Parameters:
- DATA_W, 32, instruction/IR width.
- NUM_REGS, 16, general registers; width of the one-hot select vectors.
- REG_SEL_W, 4, register field width in the IR.
- OPCODE_W, 5, opcode width, located at ir[DATA_W-1 -: OPCODE_W].

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- run  in  1  level; leaves IDLE when high.
- stop  in  1  level; sampled at instruction end.
- mem_ready  in  1  memory read data valid.
- ir  in  DATA_W  current IR contents.
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin  out  1 each  datapath strobes.
- reg_out_sel  out  NUM_REGS  one-hot register drive-to-bus.
- reg_in_sel  out  NUM_REGS  one-hot register load.
- alu_op  out  OPCODE_W  ALU function; valid while Zin=1, else 0.
- busy  out  1  state is not IDLE/HALTED.
- done  out  1  one-cycle pulse in the last step of each instruction.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- halted  out  1  high in HALTED.

Behaviour:
- IR fields: opcode = ir[31:27]; Ra = ir[26:23]; Rb = ir[22:19]; Rc = ir[18:15] (generalised by parameter).
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALTED.
- Outputs are a Moore decode of state plus the ir fields; no input except ir affects outputs combinationally.
- clr low: state goes to IDLE immediately, mid-instruction included. All outputs are 0 while clr is low and in IDLE. A restart needs run=1.
- IDLE: next state T0 if run, else IDLE.
- T0: PCout, MARin, IncPC, Zin. Next T1.
- T1: Zlowout, PCin, Read, MDRin. Next T2 if mem_ready, else T1W.
- T1W: Read, MDRin only; PCin is not re-asserted. Stays until mem_ready=1, then T2.
- T2: MDRout, IRin. Next T3.
- T3, decoded from opcode:
  - ALU op: reg_out_sel=onehot(Rb), Yin.
  - MUL/DIV: reg_out_sel=onehot(Ra), Yin.
  - NOP: no strobes; done=1; next T0 or IDLE.
  - HALT: next HALTED.
  - Undefined: illegal_op=1, done=1; next T0 or IDLE.
- T4: reg_out_sel=onehot(Rc), or onehot(Rb) for MUL/DIV; Zin; alu_op=opcode. Next T5.
- T5:
  - ALU op: Zlowout, reg_in_sel=onehot(Ra), done=1.
  - MUL/DIV: Zlowout, LOin; next T6.
- T6: Zhighout, HIin, done=1.
- Instruction end (done cycle): next IDLE if stop=1, else T0. With stop=1 the current instruction always completes first.
- HALTED: no strobes; halted=1. Exits only via clr; run is ignored.
- Latency, zero memory wait: ALU op 6 cycles (T0–T5), MUL/DIV 7 cycles, NOP/illegal 4 cycles. Each wait cycle adds one.
- At most one bit set in reg_out_sel. reg_in_sel and reg_out_sel are never both nonzero in the same cycle.

Decomposition:
- Package ctl_pkg holds:
  - Opcode constants: ADD=5'b00011, SUB=5'b00100, AND=5'b00101, OR=5'b00110, SHR=5'b00111, SHL=5'b01000, MUL=5'b01111, DIV=5'b10000, NOP=5'b11010, HALT=5'b11011.
  - State encoding constants.
  - The opcode-class function (alu/muldiv/nop/halt/illegal).
- One sub-module: ctl_step_decode, a combinational decode of state + ir into the strobe vector. The FSM register lives in instr_sequencer.

Test Plan:
- Reset clr=0, then run=1, mem_ready=1, ir=0x28918000 (and R1,R2,R3) -> T0–T5 in 6 cycles:
  - T3: reg_out_sel=16'h0004, Yin.
  - T4: reg_out_sel=16'h0008, alu_op=5'b00101, Zin.
  - T5: Zlowout, reg_in_sel=16'h0002, done.
  - Next cycle: T0.
- mem_ready low for 3 cycles after entering T1 -> Read/MDRin high 4 cycles; PCin high 1 cycle; IRin follows one cycle after mem_ready rises.
- ir=0x79A00000 (mul R3,R4) -> T3 reg_out_sel=16'h0008; T4 16'h0010 with alu_op=5'b01111; T5 Zlowout+LOin; T6 Zhighout+HIin+done.
- ir=0xF8000000 -> illegal_op and done pulse in T3; no Yin/Zin; T0 next cycle.
- ir with opcode HALT -> halted=1, busy=0 and all strobes 0 for 10+ cycles with run=1; clr pulse returns to IDLE.
- clr driven low mid-T4 -> Zin and reg_out_sel drop to 0 in the same cycle. stop=1 raised during T3 -> instruction completes with done, then IDLE with busy=0.
